register_dump: RTL
==================

# register_dump

Sequential reader for the 32-entry integer register file. On a start pulse it walks a contiguous, wrapping range of register indices through one register-file read port. It emits each word on a valid/ready stream tagged with its index, then pulses done. It serves debug/trace and end-of-test state dumps, and sits beside the core, sharing a read port with the decode stage through an external mux that the dumper does not control.

## Interface
Parameters:
- XLEN, 32, data width of a register word.

Ports:
- clock  in  1  single clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  begin a dump; sampled only in IDLE.
- first_reg  in  5  first index to dump, latched on accepted start.
- last_reg  in  5  final index to dump, latched on accepted start.
- abort  in  1  cancel a dump in progress.
- read_reg  out  5  register-file read address.
- read_data  in  XLEN  register-file read data, combinational from read_reg.
- out_valid  out  1  stream word valid.
- out_ready  in  1  downstream accepts word.
- out_index  out  5  index of the current word.
- out_data  out  XLEN  captured register value.
- out_last  out  1  current word is the final one of the dump.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse after the last word is accepted.

## Operation
- States: IDLE, FETCH, SEND, DONE.
- IDLE:
  - On start, latch first_reg into ptr and last_reg into end, then go to FETCH.
  - start while busy is ignored.
- FETCH:
  - read_reg = ptr; register read_data into out_data and ptr into out_index.
  - Set out_last = (ptr == end); go to SEND.
- SEND:
  - out_valid = 1; out_data, out_index and out_last are held stable until the handshake (out_valid & out_ready).
  - On handshake with out_last = 1, go to DONE.
  - On handshake with out_last = 0, ptr = ptr + 1 mod 32, go to FETCH.
- DONE: done = 1 for one cycle, then go to IDLE.
- Wrap rule:
  - The range is first_reg, first_reg+1, … (mod 32) up to last_reg.
  - first_reg == last_reg gives one word.
  - first_reg = last_reg + 1 (mod 32) gives all 32 words.
- x0 is dumped as whatever the read port returns (0 from the register file). The dumper does not special-case it.
- Concurrent register-file writes are not blocked; each word is the value at its FETCH cycle, so the dump is not an atomic snapshot.
- abort in FETCH/SEND/DONE: next edge goes to IDLE; out_valid drops without a handshake; done is not pulsed. abort in IDLE has no effect. abort takes priority over a same-cycle handshake.
- read_reg = ptr in every state; ptr holds its value in IDLE.

## Timing
- Reset (asynchronous): state = IDLE, ptr = 0, end = 0, read_reg = 0, out_data = 0, out_index = 0, out_valid = 0, out_last = 0, busy = 0, done = 0.
- start sampled at edge N: busy = 1 and FETCH from N; out_valid = 1 from edge N+1.
- Throughput: one word per 2 cycles with out_ready held high.
- Full 32-word dump with out_ready = 1: 64 cycles from start edge to DONE entry, plus 1 cycle of done.
- done is high for exactly the single cycle following the final handshake edge. IDLE follows, and a new start is accepted in that IDLE cycle.
- Reset asserted mid-dump: immediate return to reset values; no partial done.

## Structure
- Shared package/include: XLEN default, REG_ADDR_W = 5, NUM_REGS = 32, and state encodings (IDLE = 2'd0, FETCH = 2'd1, SEND = 2'd2, DONE = 2'd3) for reuse by a future register-load block.
- Single module. The FSM plus a 5-bit wrapping pointer is small enough that no sub-module is warranted.

## Test plan
- Preload x1..x31 = 0x1000_0000 + i; start with first = 0, last = 31, out_ready = 1.
  - Required: 32 words, index 0..31, x0 data = 0, word i data = 0x1000_0000 + i.
  - Required: out_last only on index 31; done 64 cycles after start.
- first = 30, last = 1 -> indices 30, 31, 0, 1 in order; out_last on 1. first = 5, last = 5 -> single word with out_last = 1.
- Backpressure: out_ready low for 7 cycles on word 3 -> out_data/out_index/out_last stable throughout; no word lost or duplicated.
- abort asserted in SEND of word 2 with out_ready = 1 the same cycle -> IDLE next edge; no handshake counted; no done; then start again with first = 4, last = 6 -> indices 4..6 delivered correctly.
- start while busy -> ignored; reset asserted during SEND -> out_valid = 0 and busy = 0 immediately.
- Write x7 = 0xDEAD_BEEF during the dump, before index 7 is fetched -> dumped value is 0xDEAD_BEEF.

Source files
------------

// File: rtl/register_dump_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : register_dump_pkg
//  Description : Shared definitions for the register-file dump/load family.
//                Holds the register-file geometry, the default word width,
//                the dump state encoding and a wrapping index helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package register_dump_pkg;

  // Default register word width.
  localparam int XLEN_DEFAULT = 32;

  // Register-file geometry: 32 integer registers addressed by 5 bits.
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;

  // Dump sequencer states. The encoding is fixed so that a future
  // register-load block can share decode logic and trace tooling.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_SEND  = 2'd2,
    ST_DONE  = 2'd3
  } dump_state_e;

  // Next register index, wrapping from the top of the file back to x0.
  function automatic logic [REG_ADDR_W-1:0] next_index(
    input logic [REG_ADDR_W-1:0] idx
  );
    return REG_ADDR_W'((int'(idx) + 1) % NUM_REGS);
  endfunction

endpackage : register_dump_pkg
`default_nettype wire

// File: rtl/register_dump_if.sv
`default_nettype none
// ============================================================================
//  Module      : register_dump_if
//  Description : Signal bundle between the register dumper and its
//                surroundings: dump control, the register-file read port
//                and the valid/ready output stream.
//
//  Signals:
//    start, first_reg, last_reg, abort  - dump control (into the dumper)
//    read_reg / read_data               - register-file read port
//    out_valid/out_ready/out_index/
//    out_data/out_last                  - word stream with index tag
//    busy, done                         - status
//
//  Modports:
//    master - the dumper itself
//    slave  - the environment (core, register file, stream consumer)
//  Revision    : 1.0 - initial release
// ============================================================================
interface register_dump_if
  import register_dump_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
);

  // Dump control
  logic                  start;
  logic [REG_ADDR_W-1:0] first_reg;
  logic [REG_ADDR_W-1:0] last_reg;
  logic                  abort;

  // Register-file read port (read_data is combinational from read_reg)
  logic [REG_ADDR_W-1:0] read_reg;
  logic [XLEN-1:0]       read_data;

  // Output word stream
  logic                  out_valid;
  logic                  out_ready;
  logic [REG_ADDR_W-1:0] out_index;
  logic [XLEN-1:0]       out_data;
  logic                  out_last;

  // Status
  logic                  busy;
  logic                  done;

  modport master (
    input  start, first_reg, last_reg, abort,
    input  read_data,
    input  out_ready,
    output read_reg,
    output out_valid, out_index, out_data, out_last,
    output busy, done
  );

  modport slave (
    output start, first_reg, last_reg, abort,
    output read_data,
    output out_ready,
    input  read_reg,
    input  out_valid, out_index, out_data, out_last,
    input  busy, done
  );

endinterface : register_dump_if
`default_nettype wire

// File: rtl/register_dump.sv
`default_nettype none
// ============================================================================
//  Module      : register_dump
//  Description : Sequential reader for the 32-entry integer register file.
//                A start pulse latches an inclusive, wrapping index range
//                [first_reg .. last_reg]. Each index is fetched through the
//                shared read port, captured, and offered on a valid/ready
//                stream tagged with its index. After the final word is
//                accepted, done pulses for one cycle.
//
//  Ports:
//    clock  - rising-edge clock
//    reset  - asynchronous, active-high reset
//    bus    - register_dump_if.master (control, read port, stream, status)
//
//  Each word costs one FETCH cycle and at least one SEND cycle, so the
//  stream carries one word per two cycles with out_ready held high.
//  Register-file writes are not blocked; each word reflects the register
//  contents in its own FETCH cycle, so a dump is not an atomic snapshot.
//  Revision    : 1.0 - initial release
// ============================================================================
module register_dump
  import register_dump_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic            clock,
  input  logic            reset,
  register_dump_if.master bus
);

  dump_state_e           r_state;
  logic [REG_ADDR_W-1:0] r_ptr;
  logic [REG_ADDR_W-1:0] r_end_ptr;
  logic [XLEN-1:0]       r_out_data;
  logic [REG_ADDR_W-1:0] r_out_index;
  logic                  r_out_valid;
  logic                  r_out_last;
  logic                  r_busy;
  logic                  r_done;

  // The read address is the pointer in every state; the external mux
  // decides whether the register file actually sees it.
  assign bus.read_reg  = r_ptr;
  assign bus.out_data  = r_out_data;
  assign bus.out_index = r_out_index;
  assign bus.out_valid = r_out_valid;
  assign bus.out_last  = r_out_last;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_ptr       <= '0;
      r_end_ptr   <= '0;
      r_out_data  <= '0;
      r_out_index <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      // done is a single-cycle pulse; only the SEND->DONE transition sets it.
      r_done <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          // Pointer holds its last value while idle.
          if (bus.start) begin
            r_ptr     <= bus.first_reg;
            r_end_ptr <= bus.last_reg;
            r_busy    <= 1'b1;
            r_state   <= ST_FETCH;
          end
        end

        ST_FETCH: begin
          if (bus.abort) begin
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end else begin
            // read_data is combinational from read_reg (= r_ptr) this cycle.
            r_out_data  <= bus.read_data;
            r_out_index <= r_ptr;
            r_out_last  <= (r_ptr == r_end_ptr);
            r_out_valid <= 1'b1;
            r_state     <= ST_SEND;
          end
        end

        ST_SEND: begin
          // abort wins over a handshake in the same cycle: the word is
          // withdrawn and counts as not delivered.
          if (bus.abort) begin
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_state     <= ST_IDLE;
          end else if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            if (r_out_last) begin
              r_done  <= 1'b1;
              r_state <= ST_DONE;
            end else begin
              r_ptr   <= next_index(r_ptr);
              r_state <= ST_FETCH;
            end
          end
        end

        ST_DONE: begin
          // done is already high for this cycle; an abort here changes
          // nothing since the next state is IDLE either way.
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end

        default: begin
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule : register_dump
`default_nettype wire
